// File: rtl/compare_pkg.sv
// Shared types for the sequential compare unit: predicate encodings, FSM states
// and the flag-to-predicate mapping.
package compare_pkg;

   typedef enum logic [2:0] {
      CMP_EQ  = 3'b000,
      CMP_NE  = 3'b001,
      CMP_GE  = 3'b010,
      CMP_LT  = 3'b011,
      CMP_GTU = 3'b100,
      CMP_LTU = 3'b101,
      CMP_GEU = 3'b110,
      CMP_OVF = 3'b111
   } cmp_fn_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic cmp_eval(input cmp_fn_e fn, input logic zf, input logic nf,
                                     input logic vf, input logic cf);
      logic res;
      case (fn)
         CMP_EQ:  res = zf;
         CMP_NE:  res = ~zf;
         CMP_GE:  res = ~(nf ^ vf);
         CMP_LT:  res = nf;
         CMP_GTU: res = cf & ~zf;
         CMP_LTU: res = ~cf;
         CMP_GEU: res = cf;
         CMP_OVF: res = vf;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/compare_chunk_add.sv
// One CHUNK-bit slice of a - b, computed as a + ~b + cin. Purely combinational.
module compare_chunk_add #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle relational compare: subtracts CHUNK bits per cycle, LSB chunk first.
// Define COMPARE_SEQ_DIFF_OUT_EN to also expose the full a-b difference on diff_o.
module compare_seq
   import compare_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] compare_a_i,
   input  logic [WIDTH-1:0] compare_b_i,
   input  logic [2:0]       compare_fn_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
`ifdef COMPARE_SEQ_DIFF_OUT_EN
   output logic [WIDTH-1:0] diff_o,
`endif
   output logic [WIDTH-1:0] compare_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("compare_seq: WIDTH must be a multiple of CHUNK");
   end

   state_e                       state_q, state_d;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d;
   cmp_fn_e                      fn_q, fn_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         carry_q, carry_d, zero_q, zero_d;
   logic                         nf_q, nf_d, vf_q, vf_d, cf_q, cf_d;
   logic                         res_q, res_d;
`ifdef COMPARE_SEQ_DIFF_OUT_EN
   logic [NCHUNK-1:0][CHUNK-1:0] diff_q, diff_d;
`endif

   logic [CHUNK-1:0] sum;
   logic             cout;
   logic             a_msb, b_msb;

   compare_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a_i    (a_q[cnt_q]),
      .b_i    (b_q[cnt_q]),
      .cin_i  (carry_q),
      .sum_o  (sum),
      .cout_o (cout)
   );

   assign a_msb = a_q[NCHUNK-1][CHUNK-1];
   assign b_msb = b_q[NCHUNK-1][CHUNK-1];

   // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      fn_d    = fn_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      nf_d    = nf_q;
      vf_d    = vf_q;
      cf_d    = cf_q;
      res_d   = res_q;
`ifdef COMPARE_SEQ_DIFF_OUT_EN
      diff_d  = diff_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = compare_a_i;
               b_d     = compare_b_i;
               fn_d    = cmp_fn_e'(compare_fn_i);
               cnt_d   = '0;
               carry_d = 1'b1;
               zero_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = cout;
            zero_d  = zero_q & ~(|sum);
`ifdef COMPARE_SEQ_DIFF_OUT_EN
            diff_d[cnt_q] = sum;
`endif
            if (cnt_q == LAST) begin
               // Flags and result are captured together so DONE presents a stable value.
               nf_d    = sum[CHUNK-1];
               vf_d    = (a_msb ^ b_msb) & (a_msb ^ sum[CHUNK-1]);
               cf_d    = cout;
               res_d   = cmp_eval(fn_q, zero_d, nf_d, vf_d, cf_d);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state only ever uses non-blocking assignments; all decisions live above.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         fn_q    <= CMP_EQ;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         nf_q    <= 1'b0;
         vf_q    <= 1'b0;
         cf_q    <= 1'b0;
         res_q   <= 1'b0;
`ifdef COMPARE_SEQ_DIFF_OUT_EN
         diff_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fn_q    <= fn_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         nf_q    <= nf_d;
         vf_q    <= vf_d;
         cf_q    <= cf_d;
         res_q   <= res_d;
`ifdef COMPARE_SEQ_DIFF_OUT_EN
         diff_q  <= diff_d;
`endif
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign compare_o   = {{(WIDTH-1){1'b0}}, res_q};
`ifdef COMPARE_SEQ_DIFF_OUT_EN
   assign diff_o      = diff_q;
`endif

endmodule

// File: tb/tb_compare_seq.sv
// Randomised and directed bench for compare_seq (WIDTH=32, CHUNK=8) against an
// arithmetic reference model of the predicate rules.
module tb_compare_seq;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] compare_a_i;
   logic [WIDTH-1:0] compare_b_i;
   logic [2:0]       compare_fn_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] compare_o;
`ifdef COMPARE_SEQ_DIFF_OUT_EN
   logic [WIDTH-1:0] diff_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .compare_a_i  (compare_a_i),
      .compare_b_i  (compare_b_i),
      .compare_fn_i (compare_fn_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
`ifdef COMPARE_SEQ_DIFF_OUT_EN
      .diff_o       (diff_o),
`endif
      .compare_o    (compare_o)
   );

   // Reference: predicates straight from arithmetic on the operands. Signed "lt" is
   // defined as the sign of the wrapped difference, not the true signed ordering.
   function automatic logic model(input logic [2:0] fn, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint sd = sa - sb;
      logic [WIDTH-1:0] d = a - b;
      case (fn)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return sa >= sb;
         3'd3: return d[WIDTH-1];
         3'd4: return a > b;
         3'd5: return a < b;
         3'd6: return a >= b;
         default: return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      endcase
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] fn, input int hold, input string name);
      logic [WIDTH-1:0] exp_res;
      int cycles;
      exp_res = {{(WIDTH-1){1'b0}}, model(fn, a, b)};
      n_checks++;
      if (in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_before_accept: in_ready_o=%b want 1", name, in_ready_o);
      end
      in_valid_i   = 1'b1;
      compare_a_i  = a;
      compare_b_i  = b;
      compare_fn_i = fn;
      out_ready_i  = (hold == 0);
      @(negedge clk_i);
      in_valid_i   = 1'b0;
      compare_a_i  = $urandom;
      compare_b_i  = $urandom;
      compare_fn_i = 3'($urandom);
      cycles = 0;
      while (out_valid_o !== 1'b1 && cycles < 20) begin
         @(negedge clk_i);
         cycles++;
      end
      n_checks++;
      if (cycles !== NCHUNK) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles want %0d", name, cycles, NCHUNK);
      end
      n_checks++;
      if (compare_o !== exp_res) begin
         n_fail++;
         $display("FAIL %s result: a=%h b=%h fn=%0d compare_o=%h want %h",
                  name, a, b, fn, compare_o, exp_res);
      end
`ifdef COMPARE_SEQ_DIFF_OUT_EN
      n_checks++;
      if (diff_o !== a - b) begin
         n_fail++;
         $display("FAIL %s diff: diff_o=%h want %h", name, diff_o, a - b);
      end
`endif
      for (int i = 0; i < hold; i++) begin
         in_valid_i  = 1'b1;
         compare_a_i = $urandom;
         compare_b_i = $urandom;
         @(negedge clk_i);
         n_checks++;
         if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || compare_o !== exp_res) begin
            n_fail++;
            $display("FAIL %s hold%0d: out_valid_o=%b in_ready_o=%b compare_o=%h want 1/0/%h",
                     name, i, out_valid_o, in_ready_o, compare_o, exp_res);
         end
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: out_valid_o=%b in_ready_o=%b want 0/1",
                  name, out_valid_o, in_ready_o);
      end
   endtask

   task automatic test_reset();
      rst_n_i      = 1'b0;
      in_valid_i   = 1'b0;
      out_ready_i  = 1'b1;
      compare_a_i  = '0;
      compare_b_i  = '0;
      compare_fn_i = '0;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || compare_o !== '0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready_o=%b out_valid_o=%b compare_o=%h want 1/0/0",
                  in_ready_o, out_valid_o, compare_o);
      end
`ifdef COMPARE_SEQ_DIFF_OUT_EN
      n_checks++;
      if (diff_o !== '0) begin
         n_fail++;
         $display("FAIL reset_diff: diff_o=%h want 0", diff_o);
      end
`endif
      rst_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_directed();
      run_op(32'h12345678, 32'h12345678, 3'b000, 0, "eq_same");
      run_op(32'h12345678, 32'h12345679, 3'b000, 0, "eq_diff");
      run_op(32'hFFFFFFFF, 32'h00000001, 3'b011, 0, "lt_signed");
      run_op(32'hFFFFFFFF, 32'h00000001, 3'b101, 0, "lt_unsigned");
      run_op(32'h80000000, 32'h7FFFFFFF, 3'b100, 0, "gt_unsigned");
      run_op(32'h80000000, 32'h7FFFFFFF, 3'b010, 0, "ge_signed");
      run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 0, "ovf_set");
      run_op(32'h00000005, 32'h00000003, 3'b111, 0, "ovf_clear");
   endtask

   task automatic test_backpressure();
      run_op(32'hDEADBEEF, 32'h0000BEEF, 3'b110, 5, "backpressure");
   endtask

   task automatic test_back_to_back();
      run_op(32'h00000001, 32'h00000002, 3'b101, 0, "b2b_0");
      run_op(32'h00000002, 32'h00000001, 3'b100, 0, "b2b_1");
      run_op(32'hAAAA5555, 32'hAAAA5555, 3'b001, 0, "b2b_2");
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ (32'h1 << $urandom_range(0, 31));
            default: b = $urandom;
         endcase
         run_op(a, b, 3'($urandom), $urandom_range(0, 2), "random");
      end
   endtask

   task automatic abort_check(input string name);
      #1;
      n_checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || compare_o !== '0) begin
         n_fail++;
         $display("FAIL %s: out_valid_o=%b in_ready_o=%b compare_o=%h want 0/1/0",
                  name, out_valid_o, in_ready_o, compare_o);
      end
   endtask

   task automatic test_reset_abort();
      // Abort during RUN.
      in_valid_i   = 1'b1;
      compare_a_i  = 32'h1;
      compare_b_i  = 32'h1;
      compare_fn_i = 3'b000;
      out_ready_i  = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b0;
      abort_check("abort_run");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int i = 0; i < NCHUNK + 2; i++) begin
         @(negedge clk_i);
         n_checks++;
         if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_run_no_pulse: out_valid_o=%b want 0 at cycle %0d", out_valid_o, i);
         end
      end
      run_op(32'h0, 32'h0, 3'b000, 0, "after_abort_run");
      // Abort during DONE while backpressured.
      in_valid_i   = 1'b1;
      compare_a_i  = 32'h7;
      compare_b_i  = 32'h7;
      compare_fn_i = 3'b000;
      out_ready_i  = 1'b0;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      repeat (NCHUNK + 1) @(negedge clk_i);
      rst_n_i = 1'b0;
      abort_check("abort_done");
      @(negedge clk_i);
      rst_n_i     = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      run_op(32'h0, 32'h0, 3'b000, 0, "after_abort_done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
